klein_mix_nibbles_enc: RTL

- Forward (encryption-direction) MixNibbles stage of the KLEIN-64 round datapath.
- This block is the counterpart of the decryption-side constant multipliers used by inverse MixNibbles.
- Applies AES MixColumns (circulant 02,03,01,01 over GF(2^8), polynomial 0x11B) to each 32-bit half of the 64-bit state.
- Iterative: one column per compute cycle, with valid/ready handshakes on input and output so it can sit between the round-key/sbox stage and the round register.

---
 rtl/klein_pkg.sv | 44 ++++
 rtl/klein_mix_column.sv | 42 ++++
 rtl/klein_mix_nibbles_enc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/klein_pkg.sv
// ----------------------------------------------------------------------------
// klein_pkg
// Shared definitions for the KLEIN-64 forward MixNibbles datapath.
//   - GF(2^8) reduction constant (x^8 + x^4 + x^3 + x + 1 -> low byte 0x1B)
//   - byte / column / state typedefs
//   - FSM state encoding for the iterative mixer
//   - column index constants and column get/put helpers
//   - gf_xtime: multiply a byte by {02} in GF(2^8)
// State byte order: byte0 = [63:56] ... byte7 = [7:0].
// Column 0 = bytes 0..3 = [63:32], column 1 = bytes 4..7 = [31:0].
// ----------------------------------------------------------------------------
package klein_pkg;

   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] col_t;
   typedef logic [63:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MIX  = 2'd1,
      ST_DONE = 2'd2
   } mix_state_e;

   localparam logic COL_0 = 1'b0;
   localparam logic COL_1 = 1'b1;

   // Multiply by {02}: shift left, fold the carried-out bit back via the
   // reduction polynomial.
   function automatic byte_t gf_xtime(input byte_t x);
      gf_xtime = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
   endfunction

   function automatic col_t get_col(input state_t s, input logic idx);
      get_col = (idx == COL_0) ? s[63:32] : s[31:0];
   endfunction

   function automatic state_t put_col(input state_t s, input logic idx,
                                      input col_t c);
      put_col = (idx == COL_0) ? {c, s[31:0]} : {s[63:32], c};
   endfunction

endpackage

// File: rtl/klein_mix_column.sv
// ----------------------------------------------------------------------------
// klein_mix_column
// Purely combinational AES MixColumns on one 32-bit column.
// Circulant matrix rows (02 03 01 01), all sums are byte-wise XOR.
// Ports:
//   col_in  [31:0]  a0 = [31:24] ... a3 = [7:0]
//   col_out [31:0]  b0 = [31:24] ... b3 = [7:0]
// ----------------------------------------------------------------------------
module klein_mix_column
   import klein_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   byte_t a0, a1, a2, a3;
   byte_t x0, x1, x2, x3;   // 2*a_i
   byte_t t0, t1, t2, t3;   // 3*a_i

   always_comb begin
      a0 = col_in[31:24];
      a1 = col_in[23:16];
      a2 = col_in[15:8];
      a3 = col_in[7:0];

      x0 = gf_xtime(a0);
      x1 = gf_xtime(a1);
      x2 = gf_xtime(a2);
      x3 = gf_xtime(a3);

      t0 = x0 ^ a0;
      t1 = x1 ^ a1;
      t2 = x2 ^ a2;
      t3 = x3 ^ a3;

      col_out[31:24] = x0 ^ t1 ^ a2 ^ a3;
      col_out[23:16] = a0 ^ x1 ^ t2 ^ a3;
      col_out[15:8]  = a0 ^ a1 ^ x2 ^ t3;
      col_out[7:0]   = t0 ^ a1 ^ a2 ^ x3;
   end

endmodule

// File: rtl/klein_mix_nibbles_enc.sv
// ----------------------------------------------------------------------------
// klein_mix_nibbles_enc
// Iterative forward MixNibbles stage of the KLEIN-64 round. Each 32-bit half
// of the state goes through AES MixColumns; COLS_PER_CYCLE columns are
// processed per MIX cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// out_state is held stable until out_ready is seen. The source must hold
// in_valid/in_state until accepted.
//
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   in_valid/in_ready    input handshake, in_state [STATE_W-1:0]
//   out_valid/out_ready  output handshake, out_state [STATE_W-1:0]
//   busy                 FSM is not in IDLE
//
// Timing (handshake cycle = 0): COLS_PER_CYCLE=1 -> MIX in cycles 1,2, DONE
// from cycle 3; COLS_PER_CYCLE=2 -> MIX in cycle 1, DONE from cycle 2.
// ----------------------------------------------------------------------------
module klein_mix_nibbles_enc
   import klein_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1,
   parameter int STATE_W        = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic               busy
);

   if (STATE_W != 64) begin : g_bad_state_w
      $error("klein_mix_nibbles_enc: STATE_W must be 64");
   end
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2) begin : g_bad_cols
      $error("klein_mix_nibbles_enc: COLS_PER_CYCLE must be 1 or 2");
   end

   mix_state_e state_q, state_d;
   state_t     work_q, work_d;
   logic       col_q, col_d;
   state_t     out_state_q, out_state_d;

   // Work register with the column(s) of this MIX cycle already replaced,
   // and whether this MIX cycle completes the state.
   state_t     mixed_state;
   logic       mix_last;

   if (COLS_PER_CYCLE == 2) begin : g_two_cols
      col_t m_hi, m_lo;

      klein_mix_column u_mix_hi (
         .col_in  (get_col(work_q, COL_0)),
         .col_out (m_hi)
      );
      klein_mix_column u_mix_lo (
         .col_in  (get_col(work_q, COL_1)),
         .col_out (m_lo)
      );

      assign mixed_state = {m_hi, m_lo};
      assign mix_last    = 1'b1;
   end else begin : g_one_col
      col_t m_sel;

      klein_mix_column u_mix (
         .col_in  (get_col(work_q, col_q)),
         .col_out (m_sel)
      );

      assign mixed_state = put_col(work_q, col_q, m_sel);
      assign mix_last    = (col_q == COL_1);
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      col_d       = col_q;
      out_state_d = out_state_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d  = in_state;
               col_d   = COL_0;
               state_d = ST_MIX;
            end
         end
         ST_MIX: begin
            work_d = mixed_state;
            col_d  = COL_1;
            if (mix_last) begin
               // Result is loaded straight into the output register so
               // out_state never shows a half-mixed value.
               out_state_d = mixed_state;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         col_q       <= COL_0;
         out_state_q <= '0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         col_q       <= col_d;
         out_state_q <= out_state_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_state = out_state_q;

endmodule
